instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 193 +++++++++++++++++++
 tb/tb_instr_fetch.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch unit feeding an in-order instruction buffer.
// Optional redirect alignment check is enabled by defining IFETCH_MISALIGN_CHECK_EN.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] encoded_value,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef IFETCH_MISALIGN_CHECK_EN
  ,
  output logic        misaligned
`endif
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  state_e           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      req_pc_q, req_pc_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      fifo_pc_q   [BUF_DEPTH];
  logic [31:0]      fifo_data_q [BUF_DEPTH];

  logic [31:0] redir_pc_s;
  logic        block_s;
  logic        req_valid_s;
  logic        accept_s;
  logic        push_s;
  logic        pop_s;
  logic        instr_valid_s;

`ifdef IFETCH_MISALIGN_CHECK_EN
  logic misal_q, misal_d;

  assign redir_pc_s = redirect_pc;
  assign block_s    = misal_q;
  assign misaligned = misal_q;

  // A misaligned target is latched and holds off fetch until the next redirect.
  always_comb begin
    misal_d = misal_q;
    if (redirect_valid) begin
      misal_d = (redirect_pc[1:0] != 2'b00);
    end else begin
      misal_d = misal_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      misal_q <= 1'b0;
    end else begin
      misal_q <= misal_d;
    end
  end
`else
  assign redir_pc_s = redirect_pc & 32'hFFFF_FFFC;
  assign block_s    = 1'b0;
`endif

  // Requests only issue from RUN, so "count + outstanding" reduces to count.
  assign instr_valid_s = !reset && (count_q != {CNT_W{1'b0}});
  assign req_valid_s   = !reset && (state_q == ST_RUN) && (count_q < DEPTH_C) && !block_s;
  assign accept_s      = req_valid_s && mem_req_ready;
  assign push_s        = (state_q == ST_WAIT) && mem_rsp_valid && !redirect_valid;
  assign pop_s         = instr_valid_s && instr_ready && !redirect_valid;

  // Next state: a redirect turns any in-flight request into one to drain.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (accept_s) begin
          state_d = redirect_valid ? ST_DRAIN : ST_WAIT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_WAIT: begin
        if (mem_rsp_valid) begin
          state_d = ST_RUN;
        end else if (redirect_valid) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        if (mem_rsp_valid) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (accept_s) begin
      req_pc_d = fetch_pc_q;
    end else begin
      req_pc_d = req_pc_q;
    end
    if (redirect_valid) begin
      fetch_pc_d = redir_pc_s;
      head_d     = {PTR_W{1'b0}};
      tail_d     = {PTR_W{1'b0}};
      count_d    = {CNT_W{1'b0}};
    end else begin
      if (accept_s) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (push_s) begin
        tail_d = tail_q + PTR_W'(1);
      end else begin
        tail_d = tail_q;
      end
      if (pop_s) begin
        head_d = head_q + PTR_W'(1);
      end else begin
        head_d = head_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State, pointer and buffer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= 32'h0000_0000;
      head_q     <= {PTR_W{1'b0}};
      tail_q     <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      for (int i = 0; i < BUF_DEPTH; i++) begin
        fifo_pc_q[i]   <= 32'h0000_0000;
        fifo_data_q[i] <= 32'h0000_0000;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      if (push_s) begin
        fifo_pc_q[tail_q]   <= req_pc_q;
        fifo_data_q[tail_q] <= mem_rsp_data;
      end
    end
  end

  assign mem_req_valid = req_valid_s;
  assign mem_req_addr  = fetch_pc_q;
  assign instr_valid   = instr_valid_s;
  assign encoded_value = fifo_data_q[head_q];
  assign instr_pc      = fifo_pc_q[head_q];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch; the memory returns (address ^ 32'hCAFE_0000) one cycle
// after each accepted request unless hold is set.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = 32'h0;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] encoded_value;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef IFETCH_MISALIGN_CHECK_EN
  logic        misaligned;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  logic        hold  = 1'b0;
  logic        pend  = 1'b0;
  logic [31:0] paddr = 32'h0;

  instr_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .encoded_value (encoded_value),
    .instr_pc      (instr_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
`ifdef IFETCH_MISALIGN_CHECK_EN
    ,
    .misaligned    (misaligned)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: answers the previous cycle's accept, can be held off.
  always @(negedge clk) begin
    if (pend && !hold) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = paddr ^ 32'hCAFE_0000;
      pend          = 1'b0;
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 32'h0;
    end
    if (mem_req_valid && mem_req_ready) begin
      pend  = 1'b1;
      paddr = mem_req_addr;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  // Wait for a request, check its address, then let the accepting edge pass.
  task automatic wait_req(input string tag, input logic [31:0] addr);
    int n = 0;
    while (!mem_req_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_vld"}, {31'd0, mem_req_valid}, 32'd1);
    chk(tag, mem_req_addr, addr);
    tick();
  endtask

  // Wait for the buffer head, check it, then pop it.
  task automatic wait_instr(input string tag, input logic [31:0] pc, input logic [31:0] data);
    int n = 0;
    while (!instr_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_vld"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, "_pc"}, instr_pc, pc);
    chk({tag, "_data"}, encoded_value, data);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
  endtask

  initial begin
    int n;
    reset          = 1'b1;
    mem_req_ready  = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    tick();
    tick();
    chk("rst_req_vld", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_ivld", {31'd0, instr_valid}, 32'd0);
    chk("rst_enc", encoded_value, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
`ifdef IFETCH_MISALIGN_CHECK_EN
    chk("rst_misal", {31'd0, misaligned}, 32'd0);
`endif

    // In-order fetch, buffer fill stall, refill after one pop.
    mem_req_ready = 1'b1;
    reset         = 1'b0;
    #1;
    wait_req("seq_a0", 32'h0000_0000);
    wait_req("seq_a4", 32'h0000_0004);
    repeat (4) tick();
    chk("full_stall", {31'd0, mem_req_valid}, 32'd0);
    wait_instr("seq_i0", 32'h0000_0000, 32'hCAFE_0000);
    wait_req("seq_a8", 32'h0000_0008);
    wait_instr("seq_i4", 32'h0000_0004, 32'hCAFE_0004);
    wait_instr("seq_i8", 32'h0000_0008, 32'hCAFE_0008);

    // Redirect while waiting on 0x4: its response is drained and dropped.
    do_reset();
    wait_req("rd_a0", 32'h0000_0000);
    wait_req("rd_a4", 32'h0000_0004);
    hold           = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    chk("rd_flush", {31'd0, instr_valid}, 32'd0);
    chk("rd_drain_req", {31'd0, mem_req_valid}, 32'd0);
    tick();
    chk("rd_drain_hold", {31'd0, mem_req_valid}, 32'd0);
    hold = 1'b0;
    wait_req("rd_a100", 32'h0000_0100);
    wait_instr("rd_i100", 32'h0000_0100, 32'hCAFE_0100);

    // Redirect in the same cycle as an accept, then sequential 0xFFC -> 0x1000.
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0FFC;
    tick();
    redirect_valid = 1'b0;
    chk("acc_rd_drain", {31'd0, mem_req_valid}, 32'd0);
    wait_req("seq_affc", 32'h0000_0FFC);
    wait_req("seq_a1000", 32'h0000_1000);
    wait_instr("seq_iffc", 32'h0000_0FFC, 32'hCAFE_0FFC);
    wait_instr("seq_i1000", 32'h0000_1000, 32'hCAFE_1000);

    // Address wrap at the top of the address space.
    mem_req_ready = 1'b0;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    mem_req_ready  = 1'b1;
    wait_req("wrap_afffc", 32'hFFFF_FFFC);
    wait_req("wrap_a0", 32'h0000_0000);
    wait_instr("wrap_ifffc", 32'hFFFF_FFFC, 32'h3501_FFFC);

    // Misaligned redirect target.
    mem_req_ready = 1'b0;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    tick();
    redirect_valid = 1'b0;
    mem_req_ready  = 1'b1;
`ifdef IFETCH_MISALIGN_CHECK_EN
    chk("mis_set", {31'd0, misaligned}, 32'd1);
    repeat (3) tick();
    chk("mis_noreq", {31'd0, mem_req_valid}, 32'd0);
    chk("mis_sticky", {31'd0, misaligned}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    chk("mis_clr", {31'd0, misaligned}, 32'd0);
    wait_req("mis_a200", 32'h0000_0200);
`else
    wait_req("mis_off_a100", 32'h0000_0100);
`endif

    // Reset with a buffered entry and a held outstanding request.
    do_reset();
    mem_req_ready = 1'b1;
    wait_req("rst2_a0", 32'h0000_0000);
    wait_req("rst2_a4", 32'h0000_0004);
    hold = 1'b1;
    chk("rst2_pre_ivld", {31'd0, instr_valid}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst2_req_vld0", {31'd0, mem_req_valid}, 32'd0);
    chk("rst2_ivld0", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("rst2_req_vld1", {31'd0, mem_req_valid}, 32'd0);
    chk("rst2_ivld1", {31'd0, instr_valid}, 32'd0);
    tick();
    reset = 1'b0;
    hold  = 1'b0;
    #1;
    wait_req("rst2_a0b", 32'h0000_0000);
    wait_instr("rst2_i0", 32'h0000_0000, 32'hCAFE_0000);

    // Zero-wait memory, core always ready: one instruction per two cycles.
    do_reset();
    instr_ready = 1'b1;
    n = 0;
    repeat (20) begin
      tick();
      if (instr_valid) n++;
    end
    chk("throughput", 32'(n), 32'd10);
    instr_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
